// File: rtl/afpm_pkg.sv
// afpm_pkg: shared widths, constants and sequencer state encoding for the AFPM front end
package afpm_pkg;
   localparam int FP16_W = 16;
   localparam int BYTE_W = 8;
   localparam logic [FP16_W-1:0] FP16_QNAN = 16'h7E00;
   typedef enum logic [2:0] {IDLE, LOAD_HI, ISSUE, WAIT, OUT_LO, OUT_HI} afpm_seq_state_t;
   function automatic logic is_busy(input afpm_seq_state_t s);
      return s inside {ISSUE, WAIT, OUT_LO, OUT_HI};
   endfunction
endpackage

// File: rtl/afpm_byte_sequencer_if.sv
// afpm_byte_sequencer_if: pad byte bus plus multiplier launch/return signals
interface afpm_byte_sequencer_if;
   import afpm_pkg::*;
   logic              in_valid;
   logic [BYTE_W-1:0] a_byte;
   logic [BYTE_W-1:0] b_byte;
   logic              busy;
   logic              out_valid;
   logic [BYTE_W-1:0] out_byte;
   logic              err_timeout;
   logic [FP16_W-1:0] mul_a;
   logic [FP16_W-1:0] mul_b;
   logic              mul_start;
   logic              mul_done;
   logic [FP16_W-1:0] mul_result;
   modport master (
      output in_valid, a_byte, b_byte, mul_done, mul_result,
      input  busy, out_valid, out_byte, err_timeout, mul_a, mul_b, mul_start
   );
   modport slave (
      input  in_valid, a_byte, b_byte, mul_done, mul_result,
      output busy, out_valid, out_byte, err_timeout, mul_a, mul_b, mul_start
   );
endinterface

// File: rtl/afpm_byte_sequencer.sv
// afpm_byte_sequencer: byte-serial operand assembly, one multiply with watchdog, byte-serial result
module afpm_byte_sequencer
   import afpm_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int BYTE_W      = 8,
   parameter int TIMEOUT_CYC = 16
) (
   input logic                   clk,
   input logic                   rst,
   afpm_byte_sequencer_if.slave  bus
);
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   afpm_seq_state_t   state, nxt;
   logic [DATA_W-1:0] result;
   logic [CNT_W-1:0]  cnt;
   logic              expire;
   assign expire = cnt == CNT_W'(TIMEOUT_CYC - 1);
   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    nxt = bus.in_valid ? LOAD_HI : IDLE;
         LOAD_HI: nxt = bus.in_valid ? ISSUE : LOAD_HI;
         ISSUE:   nxt = WAIT;
         WAIT:    nxt = (bus.mul_done || expire) ? OUT_LO : WAIT;
         OUT_LO:  nxt = OUT_HI;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= nxt;
   // busy and mul_start are registered from the next state so they align with it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.busy        <= 1'b0;
         bus.mul_start   <= 1'b0;
         bus.err_timeout <= 1'b0;
         bus.mul_a       <= '0;
         bus.mul_b       <= '0;
         result          <= '0;
         cnt             <= '0;
      end else begin
         bus.busy      <= is_busy(nxt);
         bus.mul_start <= nxt == ISSUE;
         if (state == IDLE && bus.in_valid) begin
            bus.mul_a[BYTE_W-1:0] <= bus.a_byte;
            bus.mul_b[BYTE_W-1:0] <= bus.b_byte;
         end
         if (state == LOAD_HI && bus.in_valid) begin
            bus.mul_a[DATA_W-1:BYTE_W] <= bus.a_byte;
            bus.mul_b[DATA_W-1:BYTE_W] <= bus.b_byte;
         end
         if (state == ISSUE) begin
            bus.err_timeout <= 1'b0;
            cnt             <= '0;
         end
         // a done arriving on the expiry cycle takes priority over the watchdog
         if (state == WAIT) begin
            if (bus.mul_done) result <= bus.mul_result;
            else if (expire) begin
               result          <= FP16_QNAN;
               bus.err_timeout <= 1'b1;
            end else cnt <= cnt + 1'b1;
         end
      end
   end
   assign bus.out_valid = state == OUT_LO || state == OUT_HI;
   assign bus.out_byte  = state == OUT_LO ? result[BYTE_W-1:0] :
                          state == OUT_HI ? result[DATA_W-1:BYTE_W] : '0;
endmodule
